// File: rtl/aes_round_ctrl_if.sv
// ----------------------------------------------------------------------------
// aes_round_ctrl_if
//   Block-request handshake between the host and the AES round controller.
//
//   Signals:
//     in_valid  host -> ctrl   new block request
//     in_ready  ctrl -> host   controller can accept a block this cycle
//     key_sel   host -> ctrl   00=AES-128, 01=AES-192, 10=AES-256, 11=reserved
//     dec       host -> ctrl   decrypt mode, sampled on handshake
//
//   Modports:
//     master    host side (drives request, observes ready)
//     slave     controller side
// ----------------------------------------------------------------------------
interface aes_round_ctrl_if;
    logic       in_valid;
    logic       in_ready;
    logic [1:0] key_sel;
    logic       dec;

    modport master (
        output in_valid,
        output key_sel,
        output dec,
        input  in_ready
    );

    modport slave (
        input  in_valid,
        input  key_sel,
        input  dec,
        output in_ready
    );
endinterface : aes_round_ctrl_if

// File: rtl/aes_round_ctrl.sv
// ----------------------------------------------------------------------------
// aes_round_ctrl
//   Round-sequencing controller for the AES core. Accepts one block per
//   valid/ready handshake and issues rounds 0..Nr (Nr = 10/12/14 chosen per
//   block by key_sel) with per-stage datapath enables. A PIPE-deep delay line
//   (stage 1 = issue register, stage PIPE = output stage) aligns the enables
//   with the datapath latency. Every entry carries its own Nr and decrypt
//   flag, so blocks of different modes can overlap in the delay line.
//   A new block is accepted in the cycle the previous block's last round
//   issues, giving Nr+1 advance cycles per block with no bubbles.
//
//   Configuration macro:
//     AES_DECRYPT_EN  defined   -> dec selects reversed round-key order
//                     undefined -> dec ignored, key_idx always equals rndNo
//
//   Parameters:
//     PIPE    delay-line depth from issue register to outputs (1..8)
//     NR_MAX  width of completed_round (14)
//
//   Ports:
//     clk              clock
//     rstn             synchronous active-low reset
//     adv              advance; all state moves only on cycles with adv=1
//     req              handshake interface (slave): in_valid/in_ready/key_sel/dec
//     accept           output stage holds round 0 of a block
//     rndNo            round number at output stage (0 on bubble)
//     key_idx          round-key index for the output stage
//     enbSB/SR/MC/AR/KS datapath stage enables
//     done             output stage holds the final round of a block
//     completed_round  one-hot of rndNo-1 at output stage
//     cfg_err          sticky: a block was accepted with reserved key_sel=11
// ----------------------------------------------------------------------------
module aes_round_ctrl #(
    parameter int PIPE   = 4,
    parameter int NR_MAX = 14
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic                adv,
    aes_round_ctrl_if.slave     req,
    output logic                accept,
    output logic [3:0]          rndNo,
    output logic [3:0]          key_idx,
    output logic                enbSB,
    output logic                enbSR,
    output logic                enbMC,
    output logic                enbAR,
    output logic                enbKS,
    output logic                done,
    output logic [NR_MAX-1:0]   completed_round,
    output logic                cfg_err
);

    // One delay-line entry.
    typedef struct packed {
        logic       valid;
        logic [3:0] rnd;
        logic [3:0] nr;
        logic       dec;
    } stage_t;

    // Decoded output bundle, registered as a whole.
    typedef struct packed {
        logic              accept;
        logic [3:0]        rnd_no;
        logic [3:0]        key_idx;
        logic              enb_sb;
        logic              enb_sr;
        logic              enb_mc;
        logic              enb_ar;
        logic              enb_ks;
        logic              done;
        logic [NR_MAX-1:0] completed;
    } out_t;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    localparam stage_t BUBBLE = '{valid: 1'b0, rnd: 4'd0, nr: 4'd0, dec: 1'b0};

    state_t  state_q;
    state_t  state_d;
    stage_t  pipe_q [1:PIPE];
    stage_t  pipe_d [1:PIPE];
    logic    cfg_err_q;
    logic    cfg_err_d;
    out_t    out_q;

    logic    ready_s;
    logic    hs_s;
    logic    dec_eff_s;
    stage_t  load_s;

    // Number of rounds for a key size; the reserved code runs as AES-128.
    function automatic logic [3:0] nr_of(input logic [1:0] ks);
        logic [3:0] nr;
        case (ks)
            2'b00:   nr = 4'd10;
            2'b01:   nr = 4'd12;
            2'b10:   nr = 4'd14;
            2'b11:   nr = 4'd10;
            default: nr = 4'd10;
        endcase
        return nr;
    endfunction

    // Datapath enables and indices for one stage entry; a bubble decodes to 0.
    function automatic out_t decode(input stage_t s);
        out_t o;
        logic nz;
        nz          = s.valid && (s.rnd != 4'd0);
        o.accept    = s.valid && (s.rnd == 4'd0);
        o.rnd_no    = s.valid ? s.rnd : 4'd0;
        o.enb_ar    = s.valid;
        o.enb_sb    = nz;
        o.enb_sr    = nz;
        o.enb_ks    = nz;
        // The final round skips MixColumns.
        o.enb_mc    = nz && (s.rnd < s.nr);
        o.done      = s.valid && (s.rnd == s.nr);
        if (s.valid) begin
            o.key_idx = s.dec ? (s.nr - s.rnd) : s.rnd;
        end else begin
            o.key_idx = 4'd0;
        end
        if (nz) begin
            o.completed = {{(NR_MAX-1){1'b0}}, 1'b1} << (s.rnd - 4'd1);
        end else begin
            o.completed = '0;
        end
        return o;
    endfunction

`ifdef AES_DECRYPT_EN
    assign dec_eff_s = req.dec;
`else
    logic dec_unused_s;
    assign dec_unused_s = req.dec;
    assign dec_eff_s    = 1'b0;
`endif

    // Ready when idle or when the issue stage is on its last round; a
    // handshake needs adv because nothing moves without it.
    assign ready_s = rstn && adv &&
                     ((state_q == ST_IDLE) || (pipe_q[1].rnd == pipe_q[1].nr));
    assign hs_s    = req.in_valid && ready_s;
    assign req.in_ready = ready_s;

    assign load_s = '{valid: 1'b1, rnd: 4'd0, nr: nr_of(req.key_sel), dec: dec_eff_s};

    // Next-state for the issue FSM, the delay line and the config error flag.
    always_comb begin
        state_d   = state_q;
        cfg_err_d = cfg_err_q;
        pipe_d    = pipe_q;
        if (adv) begin
            for (int s = 2; s <= PIPE; s++) begin
                pipe_d[s] = pipe_q[s-1];
            end
            case (state_q)
                ST_IDLE: begin
                    if (hs_s) begin
                        pipe_d[1] = load_s;
                        state_d   = ST_RUN;
                        cfg_err_d = cfg_err_q | (req.key_sel == 2'b11);
                    end else begin
                        pipe_d[1] = BUBBLE;
                    end
                end
                ST_RUN: begin
                    if (hs_s) begin
                        // Overlap: next block's round 0 follows the last round.
                        pipe_d[1] = load_s;
                        cfg_err_d = cfg_err_q | (req.key_sel == 2'b11);
                    end else if (pipe_q[1].rnd == pipe_q[1].nr) begin
                        pipe_d[1] = BUBBLE;
                        state_d   = ST_IDLE;
                    end else begin
                        pipe_d[1].rnd = pipe_q[1].rnd + 4'd1;
                    end
                end
                default: begin
                    pipe_d[1] = BUBBLE;
                    state_d   = ST_IDLE;
                end
            endcase
        end else begin
            state_d   = state_q;
            cfg_err_d = cfg_err_q;
        end
    end

    // State registers; outputs are registered from the next output-stage value
    // so they line up exactly with the output stage contents.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q   <= ST_IDLE;
            cfg_err_q <= 1'b0;
            out_q     <= '0;
            for (int s = 1; s <= PIPE; s++) begin
                pipe_q[s] <= BUBBLE;
            end
        end else begin
            state_q   <= state_d;
            cfg_err_q <= cfg_err_d;
            out_q     <= decode(pipe_d[PIPE]);
            for (int s = 1; s <= PIPE; s++) begin
                pipe_q[s] <= pipe_d[s];
            end
        end
    end

    assign accept          = out_q.accept;
    assign rndNo           = out_q.rnd_no;
    assign key_idx         = out_q.key_idx;
    assign enbSB           = out_q.enb_sb;
    assign enbSR           = out_q.enb_sr;
    assign enbMC           = out_q.enb_mc;
    assign enbAR           = out_q.enb_ar;
    assign enbKS           = out_q.enb_ks;
    assign done            = out_q.done;
    assign completed_round = out_q.completed;
    assign cfg_err         = cfg_err_q;

endmodule : aes_round_ctrl
